// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control-bundle
// layout, ALU-op encodings and the instruction-class enum used by the decoder.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 9;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Bit positions inside a flat CTRL_W-wide bundle, MSB first.
  localparam int B_ALUOP_HI = 8;
  localparam int B_ALUOP_LO = 7;
  localparam int B_ALUSRC   = 6;
  localparam int B_REGWRITE = 5;
  localparam int B_MEMTOREG = 4;
  localparam int B_MEMREAD  = 3;
  localparam int B_MEMWRITE = 2;
  localparam int B_BRANCH   = 1;
  localparam int B_JUMP     = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
  } ctrl_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JAL,
    CLS_JALR
  } op_class_e;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode decoder: classifies the opcode, then builds the control
// bundle and reports which source registers the instruction reads.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic [6:0]        op_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              uses_rs1_o,
  output logic              uses_rs2_o,
  output op_class_e         cls_o
);

  op_class_e cls;
  ctrl_t     ctrl;

  // Jumps fall into CLS_NONE when disabled, so they decode to an all-zero bubble.
  always_comb begin
    cls = CLS_NONE;
    case (op_i)
      OP_R:    cls = CLS_R;
      OP_I:    cls = CLS_I;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_JAL:  cls = ENABLE_JUMP ? CLS_JAL : CLS_NONE;
      OP_JALR: cls = ENABLE_JUMP ? CLS_JALR : CLS_NONE;
      default: cls = CLS_NONE;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (cls)
      CLS_R: begin
        ctrl.aluop    = ALUOP_FUNCT;
        ctrl.regwrite = 1'b1;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      CLS_I: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        uses_rs1_o    = 1'b1;
      end
      CLS_LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memread  = 1'b1;
        uses_rs1_o    = 1'b1;
      end
      CLS_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      CLS_BEQ: begin
        ctrl.aluop  = ALUOP_SUB;
        ctrl.branch = 1'b1;
        uses_rs1_o  = 1'b1;
        uses_rs2_o  = 1'b1;
      end
      CLS_JAL: begin
        ctrl.regwrite = 1'b1;
        ctrl.jump     = 1'b1;
      end
      CLS_JALR: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.jump     = 1'b1;
        uses_rs1_o    = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign ctrl_o = ctrl;
  assign cls_o  = cls;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, detects load-use hazards,
// and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [6:0]        op_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [REG_W-1:0]  mem_rd_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [CTRL_W-1:0] id_ctrl;
  logic              uses_rs1;
  logic              uses_rs2;
  op_class_e         id_cls;

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [REG_W-1:0]  mem_rd_q, mem_rd_d;
  logic [CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hit_rs1;
  logic hit_rs2;
  logic stall;
  logic issue;

  ctrl_decode #(
    .ENABLE_JUMP(ENABLE_JUMP)
  ) u_decode (
    .op_i      (op_i),
    .ctrl_o    (dec_ctrl),
    .uses_rs1_o(uses_rs1),
    .uses_rs2_o(uses_rs2),
    .cls_o     (id_cls)
  );

  // Writes to x0 are architecturally discarded, so never advertise them.
  always_comb begin
    id_ctrl = dec_ctrl;
    if (rd_i == '0) begin
      id_ctrl[B_REGWRITE] = 1'b0;
    end
  end

  // The bubble inserted on a stall clears ex memread, so a stall is one cycle.
  assign hit_rs1 = uses_rs1 && (ex_rd_q == rs1_i);
  assign hit_rs2 = uses_rs2 && (ex_rd_q == rs2_i);
  assign stall   = valid_i && !flush_i && ex_ctrl_q[B_MEMREAD] &&
                   (ex_rd_q != '0) && (hit_rs1 || hit_rs2);
  assign issue   = valid_i && !flush_i && !stall;

  always_comb begin
    ex_ctrl_d   = '0;
    ex_rd_d     = '0;
    if (issue) begin
      ex_ctrl_d = id_ctrl;
      ex_rd_d   = rd_i;
    end
    mem_ctrl_d  = ex_ctrl_q;
    mem_rd_d    = ex_rd_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The instruction class is only needed inside the decoder; sink it here.
  logic unused_cls;
  assign unused_cls = ^id_cls;

  assign stall_o     = stall;
  assign ex_ctrl_o   = ex_ctrl_q;
  assign ex_rd_o     = ex_rd_q;
  assign mem_ctrl_o  = mem_ctrl_q;
  assign mem_rd_o    = mem_rd_q;
  assign wb_ctrl_o   = wb_ctrl_q;
  assign wb_rd_o     = wb_rd_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (jumps on / 16-bit counter, and
// jumps off / 2-bit counter) driven by the same ID stream.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       valid;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic       flush;

  logic       stall_w   [2];
  logic [8:0] ex_ctrl_w [2];
  logic [8:0] mem_ctrl_w[2];
  logic [8:0] wb_ctrl_w [2];
  logic [4:0] ex_rd_w   [2];
  logic [4:0] mem_rd_w  [2];
  logic [4:0] wb_rd_w   [2];
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] cnt_w[2];
  assign cnt_w[0] = cnt_a;
  assign cnt_w[1] = {14'b0, cnt_b};

  pipe_ctrl_unit #(.REG_W(5), .ENABLE_JUMP(1'b1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
    .stall_o(stall_w[0]), .ex_ctrl_o(ex_ctrl_w[0]), .ex_rd_o(ex_rd_w[0]),
    .mem_ctrl_o(mem_ctrl_w[0]), .mem_rd_o(mem_rd_w[0]),
    .wb_ctrl_o(wb_ctrl_w[0]), .wb_rd_o(wb_rd_w[0]), .stall_cnt_o(cnt_a)
  );

  pipe_ctrl_unit #(.REG_W(5), .ENABLE_JUMP(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
    .stall_o(stall_w[1]), .ex_ctrl_o(ex_ctrl_w[1]), .ex_rd_o(ex_rd_w[1]),
    .mem_ctrl_o(mem_ctrl_w[1]), .mem_rd_o(mem_rd_w[1]),
    .wb_ctrl_o(wb_ctrl_w[1]), .wb_rd_o(wb_rd_w[1]), .stall_cnt_o(cnt_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stage 0 = EX, 1 = MEM, 2 = WB; index [i] selects the instance.
  logic [8:0]  m_ctrl[2][3];
  logic [4:0]  m_rd  [2][3];
  int unsigned m_cnt [2];
  bit          m_ej  [2]  = '{1'b1, 1'b0};
  int unsigned m_max [2]  = '{65535, 3};

  function automatic logic [8:0] m_decode(input logic [6:0] o, input logic [4:0] d, input bit ej);
    logic [1:0] aluop;
    logic alusrc, rw, mtr, mr, mw, br, j;
    aluop = 2'b00; alusrc = 0; rw = 0; mtr = 0; mr = 0; mw = 0; br = 0; j = 0;
    if (o == OP_R)                begin aluop = 2'b10; rw = 1; end
    else if (o == OP_I)           begin alusrc = 1; rw = 1; end
    else if (o == OP_LW)          begin alusrc = 1; rw = 1; mtr = 1; mr = 1; end
    else if (o == OP_SW)          begin alusrc = 1; mw = 1; end
    else if (o == OP_BEQ)         begin aluop = 2'b01; br = 1; end
    else if (ej && o == OP_JAL)   begin rw = 1; j = 1; end
    else if (ej && o == OP_JALR)  begin alusrc = 1; rw = 1; j = 1; end
    if (d == 5'd0) rw = 0;
    return {aluop, alusrc, rw, mtr, mr, mw, br, j};
  endfunction

  function automatic bit m_stall(input int i);
    bit u1, u2, ld;
    u1 = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (m_ej[i] && op == OP_JALR);
    u2 = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    ld = m_ctrl[i][0][3];   // memread of the instruction now in EX
    return valid && !flush && ld && (m_rd[i][0] != 0) &&
           ((u1 && m_rd[i][0] == rs1) || (u2 && m_rd[i][0] == rs2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 3; s++) begin
        m_ctrl[i][s] = '0;
        m_rd[i][s]   = '0;
      end
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      bit s;
      s = m_stall(i);
      if (s && m_cnt[i] < m_max[i]) m_cnt[i]++;
      m_ctrl[i][2] = m_ctrl[i][1]; m_rd[i][2] = m_rd[i][1];
      m_ctrl[i][1] = m_ctrl[i][0]; m_rd[i][1] = m_rd[i][0];
      if (valid && !flush && !s) begin
        m_ctrl[i][0] = m_decode(op, rd, m_ej[i]);
        m_rd[i][0]   = rd;
      end else begin
        m_ctrl[i][0] = '0;
        m_rd[i][0]   = '0;
      end
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stall[%0d]", i),    32'(stall_w[i]),    32'(m_stall(i)));
      check($sformatf("ex_ctrl[%0d]", i),  32'(ex_ctrl_w[i]),  32'(m_ctrl[i][0]));
      check($sformatf("ex_rd[%0d]", i),    32'(ex_rd_w[i]),    32'(m_rd[i][0]));
      check($sformatf("mem_ctrl[%0d]", i), 32'(mem_ctrl_w[i]), 32'(m_ctrl[i][1]));
      check($sformatf("mem_rd[%0d]", i),   32'(mem_rd_w[i]),   32'(m_rd[i][1]));
      check($sformatf("wb_ctrl[%0d]", i),  32'(wb_ctrl_w[i]),  32'(m_ctrl[i][2]));
      check($sformatf("wb_rd[%0d]", i),    32'(wb_rd_w[i]),    32'(m_rd[i][2]));
      check($sformatf("stall_cnt[%0d]", i), 32'(cnt_w[i]),     m_cnt[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a rising edge; outputs are sampled at the falling edge.
  task automatic apply(input logic v, input logic [6:0] o, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic f);
    valid = v; op = o; rs1 = a; rs2 = b; rd = d; flush = f;
    @(negedge clk);
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [6:0] o;
    logic [4:0] a, b, d;
    logic       f;
    logic       x_stall;
    logic [8:0] x_ex;
    logic [4:0] x_ex_rd;
    logic [8:0] x_ex_b;
    logic [8:0] x_wb;
  } vec_t;

  vec_t tbl[16];
  logic [6:0] op_unk;

  initial begin
    valid = 0; op = '0; rs1 = '0; rs2 = '0; rd = '0; flush = 0;
    op_unk = 7'b1111111;
    //          v  op      rs1 rs2 rd  fl  stall ex      exrd  ex_b    wb
    tbl[0]  = '{1, OP_R,   1,  2,  3,  0,  0,    9'h000, 0,    9'h000, 9'h000};
    tbl[1]  = '{1, OP_LW,  1,  0,  5,  0,  0,    9'h120, 3,    9'h120, 9'h000};
    tbl[2]  = '{1, OP_R,   5,  1,  6,  0,  1,    9'h078, 5,    9'h078, 9'h000};
    tbl[3]  = '{1, OP_R,   5,  1,  6,  0,  0,    9'h000, 0,    9'h000, 9'h120};
    tbl[4]  = '{1, OP_LW,  2,  0,  5,  0,  0,    9'h120, 6,    9'h120, 9'h078};
    tbl[5]  = '{1, OP_SW,  1,  5,  0,  0,  1,    9'h078, 5,    9'h078, 9'h000};
    tbl[6]  = '{1, OP_SW,  1,  5,  0,  0,  0,    9'h000, 0,    9'h000, 9'h120};
    tbl[7]  = '{1, OP_LW,  1,  0,  0,  0,  0,    9'h044, 0,    9'h044, 9'h078};
    tbl[8]  = '{1, OP_R,   0,  0,  7,  0,  0,    9'h058, 0,    9'h058, 9'h000};
    tbl[9]  = '{1, OP_LW,  1,  0,  5,  0,  0,    9'h120, 7,    9'h120, 9'h044};
    tbl[10] = '{1, OP_R,   5,  1,  6,  1,  0,    9'h078, 5,    9'h078, 9'h058};
    tbl[11] = '{1, OP_I,   1,  0,  0,  0,  0,    9'h000, 0,    9'h000, 9'h120};
    tbl[12] = '{1, op_unk, 0,  0,  0,  0,  0,    9'h040, 0,    9'h040, 9'h078};
    tbl[13] = '{1, OP_JAL, 0,  0,  1,  0,  0,    9'h000, 0,    9'h000, 9'h000};
    tbl[14] = '{0, OP_R,   1,  2,  9,  0,  0,    9'h021, 1,    9'h000, 9'h040};
    tbl[15] = '{0, OP_R,   1,  2,  9,  0,  0,    9'h000, 0,    9'h000, 9'h000};

    do_reset();

    for (int k = 0; k < 16; k++) begin
      apply(tbl[k].v, tbl[k].o, tbl[k].a, tbl[k].b, tbl[k].d, tbl[k].f);
      check($sformatf("tbl%0d_stall", k), 32'(stall_w[0]),    32'(tbl[k].x_stall));
      check($sformatf("tbl%0d_ex", k),    32'(ex_ctrl_w[0]),  32'(tbl[k].x_ex));
      check($sformatf("tbl%0d_ex_rd", k), 32'(ex_rd_w[0]),    32'(tbl[k].x_ex_rd));
      check($sformatf("tbl%0d_ex_b", k),  32'(ex_ctrl_w[1]),  32'(tbl[k].x_ex_b));
      check($sformatf("tbl%0d_wb", k),    32'(wb_ctrl_w[0]),  32'(tbl[k].x_wb));
      tick();
    end
    // Two load-use stalls above; the flushed pair must not count.
    check("tbl_cnt_a", 32'(cnt_a), 32'd2);
    check("tbl_cnt_b", 32'(cnt_b), 32'd2);

    // ---- asynchronous reset while a stall is active ----
    apply(1, OP_LW, 1, 0, 5, 0);
    tick();
    apply(1, OP_R, 5, 1, 6, 0);
    check("pre_rst_stall", 32'(stall_w[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_stall[%0d]", i), 32'(stall_w[i]),    32'd0);
      check($sformatf("rst_ex[%0d]", i),    32'(ex_ctrl_w[i]),  32'd0);
      check($sformatf("rst_ex_rd[%0d]", i), 32'(ex_rd_w[i]),    32'd0);
      check($sformatf("rst_mem[%0d]", i),   32'(mem_ctrl_w[i]), 32'd0);
      check($sformatf("rst_wb[%0d]", i),    32'(wb_ctrl_w[i]),  32'd0);
      check($sformatf("rst_cnt[%0d]", i),   32'(cnt_w[i]),      32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(1, OP_R, 1, 2, 3, 0);
    tick();
    apply(0, OP_R, 0, 0, 0, 0);
    check("post_rst_ex", 32'(ex_ctrl_w[0]), 32'h120);
    check("post_rst_rd", 32'(ex_rd_w[0]),   32'd3);
    tick();

    // ---- saturation of the 2-bit counter ----
    for (int p = 0; p < 4; p++) begin
      apply(1, OP_LW, 1, 0, 5, 0);
      tick();
      apply(1, OP_R, 5, 1, 6, 0);
      check($sformatf("sat_stall%0d", p), 32'(stall_w[0]), 32'd1);
      tick();
      apply(1, OP_R, 5, 1, 6, 0);
      check($sformatf("sat_nostall%0d", p), 32'(stall_w[0]), 32'd0);
      tick();
      if (p == 2) check("sat_b_at3", 32'(cnt_b), 32'd3);
    end
    apply(0, OP_R, 0, 0, 0, 0);
    check("sat_b_hold", 32'(cnt_b), 32'd3);
    check("sat_a_cnt",  32'(cnt_a), 32'd4);
    tick();

    // ---- randomized stream against the model ----
    begin
      logic [6:0] ops[8];
      bit hold;
      ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, 7'd0};
      hold = 0;
      for (int n = 0; n < 400; n++) begin
        if (!hold) begin
          valid = ($urandom_range(0, 7) != 0);
          op    = ops[$urandom_range(0, 7)];
          if (op == 7'd0) op = 7'($urandom);
          rs1   = 5'($urandom_range(0, 3));
          rs2   = 5'($urandom_range(0, 3));
          rd    = 5'($urandom_range(0, 3));
        end
        flush = ($urandom_range(0, 9) == 0);
        apply(valid, op, rs1, rs2, rd, flush);
        hold = m_stall(0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
